integral_window_builder: RTL and testbench

- Upstream feeder for the HAAR cascade comparator. Accepts a raster-ordered 20x20 window of 8-bit grayscale pixels and builds its integral image in internal storage.
- Raises START to the comparator when the image is complete.
- Serves random-access integral reads addressed by the comparator's 5-bit x/y coordinates.

---
 rtl/integral_window_builder.sv | 101 ++++++++++
 tb/tb_integral_window_builder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/integral_window_builder.sv
// integral_window_builder: builds a WINxWIN integral image from raster pixels and serves registered reads.
// Define SQ_INTEGRAL_EN to add a parallel squared-integral store and the rd_sq_data port.
module integral_window_builder #(
  parameter int WIN   = 20,
  parameter int PIX_W = 8,
  parameter int II_W  = 17
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              pixel_valid,
  output logic              pixel_ready,
  output logic              START,
  input  logic              done_ack,
  input  logic [4:0]        rd_x,
  input  logic [4:0]        rd_y,
  output logic [II_W-1:0]   rd_data
`ifdef SQ_INTEGRAL_EN
  ,
  output logic [II_W+PIX_W-1:0] rd_sq_data
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
  localparam logic [4:0] LAST = 5'(WIN - 1);
  localparam logic [4:0] EDGE = 5'(WIN);
  state_t          state_q, state_d;
  logic [4:0]      x_q, x_d, y_q, y_d;
  logic [II_W-1:0] row_q, row_d, row_n, ii;
  logic [II_W-1:0] line_q [WIN];
  logic [II_W-1:0] mem_q [WIN][WIN];
  logic            acc, clr, in_rng;
  assign pixel_ready = state_q == LOAD;
  assign START       = state_q == READY;
  assign acc         = pixel_ready && pixel_valid && !frame_start;
  assign clr         = frame_start && state_q != READY;
  assign in_rng      = rd_x < EDGE && rd_y < EDGE;
  assign row_n       = (x_q == '0 ? '0 : row_q) + II_W'(pixel_in);
  assign ii          = row_n + (y_q == '0 ? '0 : line_q[x_q]);
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    if (clr) begin
      state_d = LOAD;
      x_d     = '0;
      y_d     = '0;
      row_d   = '0;
    end else if (acc) begin
      row_d   = row_n;
      x_d     = x_q == LAST ? '0 : x_q + 5'd1;
      y_d     = x_q == LAST ? y_q + 5'd1 : y_q;
      state_d = x_q == LAST && y_q == LAST ? READY : LOAD;
    end else if (state_q == READY && done_ack) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      row_q   <= row_d;
      rd_data <= in_rng ? mem_q[rd_y][rd_x] : '0;
    end
  always_ff @(posedge Clk)
    if (acc) begin
      mem_q[y_q][x_q] <= ii;
      line_q[x_q]     <= ii;
    end
`ifdef SQ_INTEGRAL_EN
  localparam int SW = II_W + PIX_W;
  logic [2*PIX_W-1:0] psq;
  logic [SW-1:0]      rsq_q, rsq_n, sq;
  logic [SW-1:0]      lsq_q [WIN];
  logic [SW-1:0]      msq_q [WIN][WIN];
  assign psq   = pixel_in * pixel_in;
  assign rsq_n = (x_q == '0 ? '0 : rsq_q) + SW'(psq);
  assign sq    = rsq_n + (y_q == '0 ? '0 : lsq_q[x_q]);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      rsq_q      <= '0;
      rd_sq_data <= '0;
    end else begin
      rsq_q      <= clr ? '0 : acc ? rsq_n : rsq_q;
      rd_sq_data <= in_rng ? msq_q[rd_y][rd_x] : '0;
    end
  always_ff @(posedge Clk)
    if (acc) begin
      msq_q[y_q][x_q] <= sq;
      lsq_q[x_q]      <= sq;
    end
`endif
endmodule

// File: tb/tb_integral_window_builder.sv
// tb_integral_window_builder: directed checks of integral build, handshake, restart and reads.
module tb_integral_window_builder;
  logic        Clk = 0, Reset_n = 0, frame_start = 0, pixel_valid = 0, done_ack = 0;
  logic [7:0]  pixel_in = 0;
  logic [4:0]  rd_x = 0, rd_y = 0;
  logic        pixel_ready, START;
  logic [16:0] rd_data;
`ifdef SQ_INTEGRAL_EN
  logic [24:0] rd_sq_data;
`endif
  int total = 0, bad = 0;
  integral_window_builder dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .START(START),
    .done_ack(done_ack), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data)
`ifdef SQ_INTEGRAL_EN
    , .rd_sq_data(rd_sq_data)
`endif
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic frame();
    @(negedge Clk);
    frame_start = 1;
    @(negedge Clk);
    frame_start = 0;
    chk("frame_ready", pixel_ready, 1);
  endtask
  task automatic send(input int n, input bit ramp, input logic [7:0] c, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        @(negedge Clk);
        pixel_valid = 0;
        pixel_in = 8'hAA;
        chk("gap_ready", pixel_ready, 1);
      end
      @(negedge Clk);
      pixel_valid = 1;
      pixel_in = ramp ? 8'(i) : c;
      if (!pixel_ready) begin
        chk("send_ready", pixel_ready, 1);
        pixel_valid = 0;
        return;
      end
    end
  endtask
  task automatic finish_load();
    chk("start_pre", START, 0);
    @(negedge Clk);
    pixel_valid = 0;
    chk("start_rise", START, 1);
    chk("ready_drop", pixel_ready, 0);
  endtask
  task automatic rd(input logic [4:0] x, input logic [4:0] y, input logic [31:0] exp);
    @(negedge Clk);
    rd_x = x;
    rd_y = y;
    @(negedge Clk);
    chk($sformatf("rd(%0d,%0d)", x, y), rd_data, exp);
  endtask
  task automatic release_win();
    @(negedge Clk);
    done_ack = 1;
    @(negedge Clk);
    done_ack = 0;
    chk("start_fall", START, 0);
  endtask
  initial begin
    #12;
    chk("rst_ready", pixel_ready, 0);
    chk("rst_start", START, 0);
    chk("rst_rd", rd_data, 0);
    @(negedge Clk);
    Reset_n = 1;
    frame();
    send(400, 0, 8'd1, 0);
    finish_load();
    rd(0, 0, 1);
    rd(4, 2, 15);
    rd(19, 19, 400);
    release_win();
    frame();
    send(400, 0, 8'd255, 0);
    finish_load();
    rd(19, 19, 102000);
`ifdef SQ_INTEGRAL_EN
    chk("sq(19,19)", rd_sq_data, 26010000);
`endif
    rd(19, 0, 5100);
    rd(0, 19, 5100);
    release_win();
    frame();
    send(400, 1, 8'd0, 1);
    finish_load();
    rd(1, 1, 42);
    rd(19, 19, 42936);
    release_win();
    frame();
    send(150, 0, 8'd1, 0);
    pixel_valid = 0;
    Reset_n = 0;
    #1;
    chk("arst_ready", pixel_ready, 0);
    chk("arst_start", START, 0);
    chk("arst_rd", rd_data, 0);
    #2 Reset_n = 1;
    frame();
    send(400, 0, 8'd1, 0);
    finish_load();
    rd(19, 19, 400);
    release_win();
    frame();
    send(37, 0, 8'd9, 0);
    @(negedge Clk);
    frame_start = 1;
    pixel_valid = 1;
    pixel_in = 8'd9;
    done_ack = 1;
    @(negedge Clk);
    frame_start = 0;
    done_ack = 0;
    pixel_valid = 0;
    chk("restart_ready", pixel_ready, 1);
    send(400, 0, 8'd1, 0);
    finish_load();
    rd(19, 19, 400);
    rd(0, 0, 1);
    rd(20, 3, 0);
    rd(3, 20, 0);
    @(negedge Clk);
    frame_start = 1;
    @(negedge Clk);
    frame_start = 0;
    chk("fs_ready_start", START, 1);
    chk("fs_ready_pr", pixel_ready, 0);
    rd(5, 5, 36);
    @(negedge Clk);
    done_ack = 1;
    chk("ack_hold", START, 1);
    @(negedge Clk);
    done_ack = 0;
    chk("ack_start", START, 0);
    chk("idle_ready", pixel_ready, 0);
    frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
